// File: rtl/hall_axil_slave.sv
// ============================================================================
// Module   : hall_axil_slave
// Purpose  : AXI4-Lite register slave with a synchronized Hall-pulse counter
//            and a threshold interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hall_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int SYNC_STAGES        = 2
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   input  logic                              hall_in,
   output logic                              hall_irq,
   output logic [2*C_S_AXI_DATA_WIDTH-1:0]   gp_out
);

   localparam int         c_strb_w      = C_S_AXI_DATA_WIDTH / 8;
   localparam int         c_word_w      = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] c_resp_okay   = 2'b00;
   localparam logic [1:0] c_resp_slverr = 2'b10;

   logic [C_S_AXI_DATA_WIDTH-1:0] r_reg [0:3];
   logic [C_S_AXI_DATA_WIDTH-1:0] r_count;
   logic                          r_awready;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;
   logic                          r_arready;
   logic                          r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                    r_rresp;
   logic [SYNC_STAGES-1:0]        r_sync;
   logic                          r_hall_d;
   logic                          r_clr;
   logic                          r_irq;

   logic [c_word_w-1:0]           w_wr_word;
   logic [c_word_w-1:0]           w_rd_word;
   logic                          w_wr_fire;
   logic                          w_rd_fire;
   logic                          w_clr_set;
   logic                          w_hall_rise;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
   logic [1:0]                    w_rd_resp;
   logic                          w_unused;

   assign w_wr_word   = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_rd_word   = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
   // AW and W share one ready pulse so address and data are only taken together
   assign w_wr_fire   = r_awready && s00_axi_awvalid && s00_axi_wvalid;
   assign w_rd_fire   = r_arready && s00_axi_arvalid;
   assign w_clr_set   = w_wr_fire && (w_wr_word == '0) && s00_axi_wstrb[0] && s00_axi_wdata[1];
   assign w_hall_rise = r_sync[SYNC_STAGES-1] && !r_hall_d;
   assign w_unused    = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= c_resp_okay;
      end else begin
         r_awready <= s00_axi_awvalid && s00_axi_wvalid && !r_awready && !r_bvalid;
         if (w_wr_fire) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_wr_word < c_word_w'(4)) ? c_resp_okay : c_resp_slverr;
         end else if (s00_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         for (int i = 0; i < 4; i++) r_reg[i] <= '0;
         r_clr <= 1'b0;
      end else begin
         if (w_wr_fire && (w_wr_word < c_word_w'(4))) begin
            for (int b = 0; b < c_strb_w; b++) begin
               if (s00_axi_wstrb[b]) r_reg[w_wr_word[1:0]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            end
         end
         // CLR is a strobe, never stored
         r_reg[0][1] <= 1'b0;
         r_clr       <= w_clr_set;
      end
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = c_resp_slverr;
      if (w_rd_word < c_word_w'(4)) begin
         w_rd_data = r_reg[w_rd_word[1:0]];
         w_rd_resp = c_resp_okay;
      end else if (w_rd_word == c_word_w'(4)) begin
         w_rd_data = r_count;
         w_rd_resp = c_resp_okay;
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= c_resp_okay;
      end else begin
         r_arready <= s00_axi_arvalid && !r_arready && !r_rvalid;
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
         end else if (s00_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_sync   <= '0;
         r_hall_d <= 1'b0;
         r_count  <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], hall_in};
         r_hall_d <= r_sync[SYNC_STAGES-1];
         if (r_clr) begin
            r_count <= '0;
         end else if (r_reg[0][0] && w_hall_rise) begin
            r_count <= r_count + 1'b1;
         end
         r_irq <= r_reg[0][0] && (r_reg[1] != '0) && (r_count >= r_reg[1]);
      end
   end

   assign s00_axi_awready = r_awready;
   assign s00_axi_wready  = r_awready;
   assign s00_axi_bvalid  = r_bvalid;
   assign s00_axi_bresp   = r_bresp;
   assign s00_axi_arready = r_arready;
   assign s00_axi_rvalid  = r_rvalid;
   assign s00_axi_rdata   = r_rdata;
   assign s00_axi_rresp   = r_rresp;
   assign hall_irq        = r_irq;
   assign gp_out          = {r_reg[3], r_reg[2]};

endmodule

`default_nettype wire
